// File: rtl/tdc_pd_bin.sv
// tdc_pd_bin: counter-based phase detector between two clocks sampled as data.
// Reports signed phase error in sampling-clock cycles plus a lock indicator.
//
// Handshake: err_valid is a one-cycle strobe with no ready/back-pressure; the
// consumer must take phase_err/err_sat on the cycle err_valid is high. Both
// values then hold until the next strobe.
module tdc_pd_bin #(
    parameter int CNT_W       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_CNT    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic           clk_ref,
    input  logic           fb_clk,
    output logic [CNT_W:0] phase_err,
    output logic           err_valid,
    output logic           err_sat,
    output logic           locked,
    output logic [1:0]     state_dbg
);

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] MAXC     = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(LOCK_TOL);
    localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_CNT);

    typedef enum logic [1:0] {
        ARM      = 2'd0,
        IDLE     = 2'd1,
        LEAD_REF = 2'd2,
        LEAD_FB  = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] ref_sync, fb_sync;
    logic                   ref_hist, fb_hist;
    logic                   ref_rise, fb_rise;
    logic [CNT_W-1:0]       cnt, cnt_next, cnt_inc;
    logic                   pub, pub_neg, in_tol;
    logic [CNT_W-1:0]       pub_mag;
    logic [CNT_W:0]         mag_ext, pub_val;
    logic [LW-1:0]          lock_cnt, lock_next;

    // Synchronize both clocks through equal-depth chains plus a history flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_sync <= '0;
            fb_sync  <= '0;
            ref_hist <= 1'b0;
            fb_hist  <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], clk_ref};
            fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_clk};
            ref_hist <= ref_sync[SYNC_STAGES-1];
            fb_hist  <= fb_sync[SYNC_STAGES-1];
        end
    end

    assign ref_rise  = ref_sync[SYNC_STAGES-1] & ~ref_hist;
    assign fb_rise   = fb_sync[SYNC_STAGES-1] & ~fb_hist;
    assign cnt_inc   = (cnt == MAXC) ? MAXC : cnt + ONE;
    assign state_dbg = state;

    // State and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARM;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, counter and publication decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pub        = 1'b0;
        pub_neg    = 1'b0;
        pub_mag    = '0;
        if (!en) begin
            state_next = ARM;
            cnt_next   = '0;
        end else begin
            unique case (state)
                ARM: begin
                    // Arming edge is consumed, never measured
                    if (ref_rise) state_next = IDLE;
                end
                IDLE: begin
                    if (ref_rise && fb_rise) begin
                        pub = 1'b1;
                    end else if (ref_rise) begin
                        state_next = LEAD_REF;
                        cnt_next   = ONE;
                    end else if (fb_rise) begin
                        state_next = LEAD_FB;
                        cnt_next   = ONE;
                    end
                end
                LEAD_REF: begin
                    if (fb_rise) begin
                        pub     = 1'b1;
                        pub_mag = cnt;
                        if (ref_rise) begin
                            // Coincident new ref edge opens the next measurement
                            cnt_next = ONE;
                        end else begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end
                    end else if (ref_rise) begin
                        // Cycle slip: report full scale and restart from this edge
                        pub      = 1'b1;
                        pub_mag  = MAXC;
                        cnt_next = ONE;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                LEAD_FB: begin
                    pub_neg = 1'b1;
                    if (ref_rise) begin
                        pub     = 1'b1;
                        pub_mag = cnt;
                        if (fb_rise) begin
                            cnt_next = ONE;
                        end else begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end
                    end else if (fb_rise) begin
                        pub      = 1'b1;
                        pub_mag  = MAXC;
                        cnt_next = ONE;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: state_next = ARM;
            endcase
        end
    end

    assign mag_ext = {1'b0, pub_mag};
    assign pub_val = pub_neg ? (~mag_ext + (CNT_W+1)'(1)) : mag_ext;
    assign in_tol  = (pub_mag <= TOL_C) && (pub_mag != MAXC);

    // Lock counter next value: clears on disable or on any out-of-tolerance result
    always_comb begin
        lock_next = lock_cnt;
        if (!en) begin
            lock_next = '0;
        end else if (pub) begin
            if (!in_tol)                  lock_next = '0;
            else if (lock_cnt != LOCK_MAX) lock_next = lock_cnt + LW'(1);
        end
    end

    // Registered outputs and lock tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_err <= '0;
            err_valid <= 1'b0;
            err_sat   <= 1'b0;
            lock_cnt  <= '0;
            locked    <= 1'b0;
        end else begin
            err_valid <= pub;
            lock_cnt  <= lock_next;
            locked    <= (lock_next == LOCK_MAX);
            if (pub) begin
                phase_err <= pub_val;
                err_sat   <= (pub_mag == MAXC);
            end
        end
    end

endmodule

// File: tb/tb_tdc_pd_bin.sv
// Bench for tdc_pd_bin: timestamp-based reference model compared every cycle,
// plus a literal queue of expected publications from directed scenarios.
module tb_tdc_pd_bin;

    localparam int CNT_W = 5;
    localparam int SS    = 2;
    localparam int TOL   = 1;
    localparam int LCNT  = 4;
    localparam int MAXC  = 31;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           en = 1'b0;
    logic           clk_ref = 1'b0;
    logic           fb_clk = 1'b0;
    logic [CNT_W:0] phase_err;
    logic           err_valid;
    logic           err_sat;
    logic           locked;
    logic [1:0]     state_dbg;

    int checks = 0;
    int failures = 0;
    bit done = 1'b0;

    // expected publications: {err_sat, phase_err}
    logic [CNT_W+1:0] exp_q[$];

    tdc_pd_bin #(.CNT_W(CNT_W), .SYNC_STAGES(SS), .LOCK_TOL(TOL), .LOCK_CNT(LCNT)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .clk_ref(clk_ref), .fb_clk(fb_clk),
        .phase_err(phase_err), .err_valid(err_valid), .err_sat(err_sat),
        .locked(locked), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 waiting for arm, 1 idle, 2 ref leads, 3 fb leads.
    int   m_mode = 0, m_t0 = 0, m_cyc = 0, m_lock = 0, m_pe = 0;
    logic m_valid = 0, m_sat = 0, m_locked = 0;
    logic m_prev_ref = 0, m_prev_fb = 0;
    logic r_dl[$], f_dl[$];

    task automatic m_pub(input int v);
        int mag;
        mag      = (v < 0) ? -v : v;
        m_pe     = v;
        m_sat    = (mag == MAXC);
        m_valid  = 1'b1;
        if (mag <= TOL && !m_sat) m_lock = (m_lock + 1 > LCNT) ? LCNT : m_lock + 1;
        else                      m_lock = 0;
        m_locked = (m_lock == LCNT);
    endtask

    function automatic int span_mag(input int t0, input int t1);
        return (t1 - t0 > MAXC) ? MAXC : t1 - t0;
    endfunction

    initial forever begin
        logic rr, fr;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_mode = 0; m_cyc = 0; m_lock = 0; m_pe = 0;
            m_valid = 0; m_sat = 0; m_locked = 0;
            m_prev_ref = 0; m_prev_fb = 0;
            r_dl.delete(); f_dl.delete();
        end else begin
            r_dl.push_back(clk_ref & ~m_prev_ref);
            f_dl.push_back(fb_clk & ~m_prev_fb);
            m_prev_ref = clk_ref;
            m_prev_fb  = fb_clk;
            rr = (r_dl.size() > SS) ? r_dl.pop_front() : 1'b0;
            fr = (f_dl.size() > SS) ? f_dl.pop_front() : 1'b0;
            m_valid = 1'b0;
            if (!en) begin
                m_mode = 0; m_lock = 0; m_locked = 0;
            end else begin
                case (m_mode)
                    0: if (rr) m_mode = 1;
                    1: begin
                        if (rr && fr) m_pub(0);
                        else if (rr) begin m_mode = 2; m_t0 = m_cyc; end
                        else if (fr) begin m_mode = 3; m_t0 = m_cyc; end
                    end
                    2: begin
                        if (fr) begin
                            m_pub(span_mag(m_t0, m_cyc));
                            if (rr) m_t0 = m_cyc; else m_mode = 1;
                        end else if (rr) begin
                            m_pub(MAXC); m_t0 = m_cyc;
                        end
                    end
                    default: begin
                        if (rr) begin
                            m_pub(-span_mag(m_t0, m_cyc));
                            if (fr) m_t0 = m_cyc; else m_mode = 1;
                        end else if (fr) begin
                            m_pub(-MAXC); m_t0 = m_cyc;
                        end
                    end
                endcase
            end
            m_cyc++;
        end
    end

    // ---------------- compare process + scoreboard ----------------
    initial forever begin
        @(negedge clk);
        if (!done) begin
            chk("err_valid", int'(err_valid), int'(m_valid));
            chk("phase_err", int'($signed(phase_err)), m_pe);
            chk("err_sat", int'(err_sat), int'(m_sat));
            chk("locked", int'(locked), int'(m_locked));
            if (err_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pub actual=%0d required=none at %0t",
                             int'({err_sat, phase_err}), $time);
                end else begin
                    chk("pub_value", int'({err_sat, phase_err}), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drive 3-cycle-high pulses starting at the given offsets (-1 = no pulse).
    task automatic pair(input int ro, input int fo, input int span);
        for (int c = 0; c < span; c++) begin
            @(negedge clk); #1;
            clk_ref = (ro >= 0 && c >= ro && c < ro + 3);
            fb_clk  = (fo >= 0 && c >= fo && c < fo + 3);
        end
    endtask

    task automatic idle(input int n);
        pair(-1, -1, n);
    endtask

    task automatic expect_pub(input logic sat, input logic [CNT_W:0] pe);
        exp_q.push_back({sat, pe});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_phase_err", int'(phase_err), 0);
        chk("rst_err_valid", int'(err_valid), 0);
        chk("rst_err_sat", int'(err_sat), 0);
        chk("rst_locked", int'(locked), 0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        en = 1'b1;

        // fb edge while unarmed is ignored, then ref arms
        pair(-1, 0, 6);
        pair(0, -1, 6);

        expect_pub(1'b0, 6'd3);
        pair(0, 3, 8);
        expect_pub(1'b0, 6'b111001);
        pair(7, 0, 12);

        expect_pub(1'b1, 6'd31);
        pair(0, 40, 45);
        idle(4);
        chk("locked_after_sat", int'(locked), 0);

        for (int i = 0; i < 4; i++) begin
            expect_pub(1'b0, 6'd0);
            pair(0, 0, 6);
            if (i == 2) chk("locked_after_3", int'(locked), 0);
        end
        chk("locked_after_4", int'(locked), 1);

        expect_pub(1'b0, 6'd5);
        pair(0, 5, 10);
        chk("locked_after_plus5", int'(locked), 0);
        chk("phase_err_plus5", int'(phase_err), 5);

        // cycle slip then a measurement restarted from the second ref edge
        expect_pub(1'b1, 6'd31);
        expect_pub(1'b0, 6'd8);
        pair(0, -1, 6);
        pair(0, -1, 5);
        pair(-1, 3, 6);
        idle(4);

        // reset mid LEAD_REF aborts the measurement
        pair(0, -1, 6);
        @(negedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst2_phase_err", int'(phase_err), 0);
        chk("rst2_err_sat", int'(err_sat), 0);
        chk("rst2_err_valid", int'(err_valid), 0);
        #1;
        reset_n = 1'b1;
        pair(0, -1, 6);
        expect_pub(1'b0, 6'd2);
        pair(0, 2, 6);

        // en dropped mid LEAD_FB: outputs hold, no publication
        pair(-1, 0, 6);
        @(negedge clk); #1;
        en = 1'b0;
        idle(3);
        chk("en_hold_phase_err", int'(phase_err), 2);
        chk("en_hold_err_sat", int'(err_sat), 0);
        @(negedge clk); #1;
        en = 1'b1;
        pair(0, -1, 6);
        expect_pub(1'b0, 6'b111111);
        pair(1, 0, 6);
        idle(4);

        chk("exp_q_empty", exp_q.size(), 0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdc_pd_bin.md
TDC_PD_BIN -- requirements
Module: tdc_pd_bin

Interface
REQ-001 SHALL have parameter CNT_W, default 5: magnitude width of the phase counter; MAXC = 2^CNT_W-1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for clk_ref and fb_clk, minimum 2.
REQ-003 SHALL have parameter LOCK_TOL, default 1: largest |phase_err| counted as in-lock.
REQ-004 SHALL have parameter LOCK_CNT, default 4: consecutive in-tolerance measurements required to assert locked.
REQ-005 SHALL have port clk  input  1  sampling clock; the single clock of the block.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port en  input  1  measurement enable.
REQ-008 SHALL have port clk_ref  input  1  reference clock, asynchronous to clk, sampled as data.
REQ-009 SHALL have port fb_clk  input  1  feedback (DCO-divided) clock, asynchronous to clk, sampled as data.
REQ-010 SHALL have port phase_err  output  CNT_W+1  signed two's-complement phase error in clk cycles; positive means clk_ref leads.
REQ-011 SHALL have port err_valid  output  1  one-cycle strobe marking a new phase_err.
REQ-012 SHALL have port err_sat  output  1  qualifies the current phase_err as saturated or cycle-slipped.
REQ-013 SHALL have port locked  output  1  lock indicator.

Function
REQ-014 SHALL pass clk_ref and fb_clk through SYNC_STAGES flops each, followed by one history flop; rise = sync & ~hist. Both paths SHALL have identical latency.
REQ-015 SHALL implement the FSM states ARM, IDLE, LEAD_REF and LEAD_FB.
REQ-016 ARM: the first ref_rise while en=1 SHALL move the FSM to IDLE. That edge SHALL NOT be measured. fb_rise SHALL be ignored in ARM.
REQ-017 IDLE, ref_rise and fb_rise in the same cycle: SHALL publish phase_err=0 and err_sat=0, and SHALL stay in IDLE.
REQ-018 IDLE, ref_rise only: SHALL go to LEAD_REF with cnt<=1. IDLE, fb_rise only: SHALL go to LEAD_FB with cnt<=1.
REQ-019 LEAD_REF/LEAD_FB: cnt SHALL increment by 1 per cycle and SHALL hold at MAXC (no wrap).
REQ-020 Measurement closure: with the leading edge detected at cycle t and the lagging edge at cycle t+k, the published |phase_err| SHALL be min(k, MAXC).
REQ-021 LEAD_REF, fb_rise: SHALL publish +cnt and go to IDLE. LEAD_FB, ref_rise: SHALL publish -cnt and go to IDLE.
REQ-022 err_sat SHALL be 1 when the published magnitude equals MAXC, and 0 otherwise.
REQ-023 Cycle slip, LEAD_REF with a second ref_rise and no fb_rise: SHALL publish +MAXC with err_sat=1, stay in LEAD_REF, and set cnt<=1. The mirror case (LEAD_FB, second fb_rise) SHALL publish -MAXC.
REQ-024 LEAD_REF with ref_rise and fb_rise in the same cycle: SHALL publish +cnt, stay in LEAD_REF, and set cnt<=1 (the new ref edge opens the next measurement). The mirror rule SHALL apply in LEAD_FB.
REQ-025 Publishing SHALL register phase_err and err_sat on the clock edge that samples the terminating rise, and SHALL assert err_valid for exactly one cycle.
REQ-026 Between publications, phase_err and err_sat SHALL hold their values.
REQ-027 en=0 (any state): the FSM SHALL go to ARM, cnt SHALL clear, no publication SHALL occur, and the lock counter and locked SHALL clear. phase_err and err_sat SHALL hold.
REQ-028 Lock: each err_valid with |phase_err|<=LOCK_TOL and err_sat=0 SHALL increment lock_cnt, saturating at LOCK_CNT. locked SHALL be 1 when lock_cnt=LOCK_CNT.
REQ-029 Any err_valid failing the REQ-028 condition SHALL clear lock_cnt and locked on the same edge that publishes it.
REQ-030 All outputs SHALL be driven directly from flops.

Reset
REQ-031 On reset_n=0, the block SHALL asynchronously set: synchronizer and history flops 0, state ARM, cnt 0, phase_err 0, err_valid 0, err_sat 0, lock_cnt 0, locked 0.
REQ-032 Reset release SHALL be synchronous to clk. Assertion mid-measurement SHALL abort that measurement and SHALL NOT publish it.

Verification
REQ-033 With defaults: reset, en=1, one arming ref edge, then ref_rise at t and fb_rise at t+3 -> err_valid at the t+3 edge with phase_err=+3, err_sat=0.
REQ-034 fb_rise at t and ref_rise at t+7 -> phase_err=-7 (6'b111001), err_sat=0.
REQ-035 ref_rise with no fb for 40 cycles, then fb_rise -> phase_err=+31, err_sat=1, and locked stays 0.
REQ-036 Coincident ref/fb rises for 4 periods -> four err_valid pulses with phase_err=0, and locked=1 after the 4th. One following measurement of +5 -> locked=0 on that same edge.
REQ-037 Two ref edges without an fb edge -> +31 with err_sat=1 on the second ref edge, and a new measurement starts with cnt=1.
REQ-038 reset_n pulsed low in LEAD_REF, and separately en dropped in LEAD_FB -> no err_valid; all outputs at reset values (reset case) or held (en case); the next ref edge is consumed as the arming edge.
